// File: rtl/sha2_core_if.sv
// Request/response bundle for sha2_core: block request side (init/next/mode/block)
// and result side (ready/digest/digest_valid).
interface sha2_core_if;
   logic         init;
   logic         next;
   logic         mode;
   logic [511:0] block;
   logic         ready;
   logic [255:0] digest;
   logic         digest_valid;

   modport master (output init, next, mode, block,
                   input  ready, digest, digest_valid);
   modport slave  (input  init, next, mode, block,
                   output ready, digest, digest_valid);
endinterface

// File: rtl/sha2_core.sv
// SHA-256/224 block compression core, UNROLL rounds per clock (1, 2 or 4).
// Define SHA2_CORE_MODE224_EN to enable SHA-224 IV and truncated digest via bus.mode.
module sha2_core #(
   parameter int UNROLL = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   sha2_core_if.slave  bus
);

   if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
      $error("sha2_core: UNROLL must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {IDLE, ROUNDS, DONE} state_t;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] IV256 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Working state packed as {a,b,c,d,e,f,g,h}, a in the top word.
   function automatic logic [255:0] round_f(input logic [255:0] s, input logic [31:0] k,
                                            input logic [31:0] w);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = s;
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      return {t1 + t2, a, b, c, d + t1, e, f, g};
   endfunction

   state_t       state_q, state_d;
   logic [255:0] h_q, s_q, s_next, iv_sel;
   logic [31:0]  w_q [16];
   logic [31:0]  w_next [16];
   logic [6:0]   cnt_q;
   logic         dv_q, accept_init, accept_next;

   // The W window always holds W[t..t+15]; extending it by UNROLL words gives every
   // schedule word the unrolled rounds need, and the shifted tail is the next window.
   always_comb begin : round_chain
      logic [31:0]  ext [16 + UNROLL];
      logic [255:0] st;
      logic [5:0]   t;
      for (int i = 0; i < 16; i++) ext[i] = w_q[i];
      for (int u = 0; u < UNROLL; u++)
         ext[16 + u] = sig1(ext[14 + u]) + ext[9 + u] + sig0(ext[1 + u]) + ext[u];
      st = s_q;
      t  = '0;
      for (int u = 0; u < UNROLL; u++) begin
         t  = cnt_q[5:0] + 6'(u);
         st = round_f(st, K[t], ext[u]);
      end
      s_next = st;
      for (int i = 0; i < 16; i++) w_next[i] = ext[i + UNROLL];
   end

   always_comb begin
      state_d     = state_q;
      accept_init = 1'b0;
      accept_next = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.init) begin
               accept_init = 1'b1;
               state_d     = ROUNDS;
            end else if (bus.next) begin
               accept_next = 1'b1;
               state_d     = ROUNDS;
            end
         end
         ROUNDS:  if (cnt_q == 7'(64 - UNROLL)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_q   <= '0;
         s_q   <= '0;
         cnt_q <= '0;
         dv_q  <= 1'b0;
         for (int i = 0; i < 16; i++) w_q[i] <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_init || accept_next) begin
                  if (accept_init) begin
                     h_q <= iv_sel;
                     s_q <= iv_sel;
                  end else begin
                     s_q <= h_q;
                  end
                  cnt_q <= '0;
                  dv_q  <= 1'b0;
                  for (int i = 0; i < 16; i++) w_q[i] <= bus.block[511 - 32*i -: 32];
               end
            end
            ROUNDS: begin
               s_q   <= s_next;
               w_q   <= w_next;
               cnt_q <= cnt_q + 7'(UNROLL);
            end
            DONE: begin
               for (int i = 0; i < 8; i++) h_q[32*i +: 32] <= h_q[32*i +: 32] + s_q[32*i +: 32];
               dv_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef SHA2_CORE_MODE224_EN
   localparam logic [255:0] IV224 = {
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };
   logic mode_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)         mode_q <= 1'b0;
      else if (accept_init) mode_q <= bus.mode;
   end

   assign iv_sel     = bus.mode ? IV224 : IV256;
   assign bus.digest = mode_q ? {h_q[255:32], 32'h0} : h_q;
`else
   logic unused_mode;
   assign unused_mode = bus.mode;
   assign iv_sel      = IV256;
   assign bus.digest  = h_q;
`endif

   assign bus.ready        = (state_q == IDLE);
   assign bus.digest_valid = dv_q;

endmodule

// File: tb/tb_sha2_core.sv
// Directed scoreboard bench for sha2_core, running UNROLL=1, 2 and 4 side by side
// on identical stimulus.
module tb_sha2_core;

   localparam int UNR [3] = '{1, 2, 4};

   localparam logic [511:0] ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
   localparam logic [511:0] TWO_B1 = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] TWO_B2 = {{15{32'h0}}, 32'h000001c0};
   localparam logic [255:0] D256 = {
      32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
   localparam logic [255:0] D224 = {
      32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
      32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h00000000};
   localparam logic [255:0] DTWO = {
      32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
      32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

   logic clk;
   logic reset_n;
   int   total;
   int   passed;
   logic [255:0] exp_q [$];

   sha2_core_if if1 ();
   sha2_core_if if2 ();
   sha2_core_if if4 ();

   sha2_core #(.UNROLL(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
   sha2_core #(.UNROLL(2)) u2 (.clk(clk), .reset_n(reset_n), .bus(if2));
   sha2_core #(.UNROLL(4)) u4 (.clk(clk), .reset_n(reset_n), .bus(if4));

   logic [2:0]   rdy_a, dv_a;
   logic [255:0] dig_a [3];
   assign rdy_a    = {if4.ready, if2.ready, if1.ready};
   assign dv_a     = {if4.digest_valid, if2.digest_valid, if1.digest_valid};
   assign dig_a[0] = if1.digest;
   assign dig_a[1] = if2.digest;
   assign dig_a[2] = if4.digest;

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic driveAll(input logic i, input logic n, input logic m, input logic [511:0] blk);
      if1.init = i; if1.next = n; if1.mode = m; if1.block = blk;
      if2.init = i; if2.next = n; if2.mode = m; if2.block = blk;
      if4.init = i; if4.next = n; if4.mode = m; if4.block = blk;
   endtask

   task automatic checkIdleReset(input string tag);
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("%s_ready_u%0d", tag, UNR[k]), 256'(rdy_a[k]), 256'(1));
         checkOutput($sformatf("%s_digest_u%0d", tag, UNR[k]), dig_a[k], '0);
         checkOutput($sformatf("%s_dv_u%0d", tag, UNR[k]), 256'(dv_a[k]), 256'(0));
      end
   endtask

   // One block on all three cores; optional busy init pulse and mid-block reset.
   task automatic applyStimulus(input string tag, input logic i, input logic n, input logic m,
                                input logic [511:0] blk, input bit has_exp,
                                input logic [255:0] exp, input int pulse_at, input int abort_at);
      int low [3];
      bit done [3];
      logic [255:0] e;
      low  = '{0, 0, 0};
      done = '{0, 0, 0};
      @(negedge clk);
      driveAll(i, n, m, blk);
      if (has_exp) exp_q.push_back(exp);
      @(negedge clk);
      driveAll(1'b0, 1'b0, 1'b0, ~blk);
      for (int it = 1; it <= 100 && !(done[0] && done[1] && done[2]); it++) begin
         if (it == abort_at) begin
            reset_n = 1'b0;
            #1;
            checkIdleReset({tag, "_rst"});
            @(negedge clk);
            reset_n = 1'b1;
            if (has_exp) void'(exp_q.pop_front());
            return;
         end
         if (it == pulse_at) driveAll(1'b1, 1'b1, 1'b1, ~blk);
         else if (it == pulse_at + 1) driveAll(1'b0, 1'b0, 1'b0, ~blk);
         for (int k = 0; k < 3; k++)
            if (!done[k]) begin
               if (!rdy_a[k]) low[k]++;
               else done[k] = 1'b1;
            end
         @(negedge clk);
      end
      driveAll(1'b0, 1'b0, 1'b0, ~blk);
      e = '0;
      if (has_exp) e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("%s_busy_u%0d", tag, UNR[k]), 256'(low[k]), 256'(64 / UNR[k] + 1));
         checkOutput($sformatf("%s_dv_u%0d", tag, UNR[k]), 256'(dv_a[k]), 256'(1));
         if (has_exp) checkOutput($sformatf("%s_digest_u%0d", tag, UNR[k]), dig_a[k], e);
      end
   endtask

   task automatic checkHold(input string tag, input logic [255:0] exp);
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("%s_dv_u%0d", tag, UNR[k]), 256'(dv_a[k]), 256'(1));
         checkOutput($sformatf("%s_digest_u%0d", tag, UNR[k]), dig_a[k], exp);
      end
   endtask

   initial begin
      clk     = 1'b0;
      reset_n = 1'b0;
      total   = 0;
      passed  = 0;
      driveAll(1'b0, 1'b0, 1'b0, '0);
      repeat (2) @(negedge clk);
      checkIdleReset("reset");
      reset_n = 1'b1;

      applyStimulus("abc256", 1'b1, 1'b0, 1'b0, ABC, 1'b1, D256, -1, -1);
      checkHold("abc256_hold", D256);

`ifdef SHA2_CORE_MODE224_EN
      applyStimulus("abc224", 1'b1, 1'b0, 1'b1, ABC, 1'b1, D224, -1, -1);
`else
      applyStimulus("abc_mode_ignored", 1'b1, 1'b0, 1'b1, ABC, 1'b1, D256, -1, -1);
`endif

      applyStimulus("two_blk1", 1'b1, 1'b0, 1'b0, TWO_B1, 1'b0, '0, -1, -1);
      applyStimulus("two_blk2", 1'b0, 1'b1, 1'b1, TWO_B2, 1'b1, DTWO, -1, -1);

      applyStimulus("init_next_pulse", 1'b1, 1'b1, 1'b0, ABC, 1'b1, D256, 5, -1);

      applyStimulus("abort", 1'b1, 1'b0, 1'b0, ABC, 1'b1, D256, -1, 30);
      applyStimulus("after_reset", 1'b1, 1'b0, 1'b0, ABC, 1'b1, D256, -1, -1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
